spike_window_classifier: RTL and testbench

SPIKE_WINDOW_CLASSIFIER -- requirements
Module: spike_window_classifier

---
 rtl/spike_window_classifier.sv | 180 ++++++++++++++++++
 tb/tb_spike_window_classifier.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_window_classifier.sv
// ---------------------------------------------------------------------------
// spike_window_classifier
//
// Counts rising edges of the winner spike line over fixed windows of
// WINDOW_CYCLES clock cycles and reports each window's count together with a
// LOW / NORMAL / HIGH class through a valid/ready result register. A result
// that completes while the previous one is still unconsumed is dropped and
// flagged on the sticky overrun_o output.
//
// The cycle in which enable_i first rises is spent entering RUN; window
// cycle 0 is the following cycle.
//
// Ports
//   clk_i           sole clock
//   rst_i           asynchronous reset, active low
//   enable_i        windowing enable; low abandons the current window
//   spike_i         winner spike level from the upstream network
//   result_ready_i  consumer ready
//   result_valid_o  result valid, held until transferred
//   spike_count_o   spike count of the reported window (saturating)
//   class_o         00 NORMAL, 01 LOW, 10 HIGH
//   overrun_o       sticky: a completed window was dropped (reset clears)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | not windowing; counters held at zero
// ST_RUN   | counting window cycles and spike events
// ---------------------------------------------------------------------------
module spike_window_classifier #(
    parameter int WINDOW_CYCLES = 1200000,
    parameter int CNT_W         = 16,
    parameter int LOW_THR       = 2,
    parameter int HIGH_THR      = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             spike_i,
    input  logic             result_ready_i,
    output logic             result_valid_o,
    output logic [CNT_W-1:0] spike_count_o,
    output logic [1:0]       class_o,
    output logic             overrun_o
);

    localparam int               WIN_W    = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [1:0] CLASS_NORMAL = 2'b00;
    localparam logic [1:0] CLASS_LOW    = 2'b01;
    localparam logic [1:0] CLASS_HIGH   = 2'b10;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIN_W-1:0]   win_cnt_q;
    logic [WIN_W-1:0]   win_cnt_d;
    logic [CNT_W-1:0]   spike_cnt_q;
    logic [CNT_W-1:0]   spike_cnt_d;
    logic               spike_q;

    logic               spike_evt;
    logic [CNT_W-1:0]   spike_inc;
    logic               win_end;
    logic               transfer;
    logic               load_result;
    logic [1:0]         win_class;
    logic [31:0]        count_ext;

    // Previous-sample register runs every cycle so an edge is never invented
    // by enabling while the spike line is already high.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            spike_q <= 1'b0;
        end else begin
            spike_q <= spike_i;
        end
    end

    assign spike_evt = spike_i & ~spike_q;

    // Count including this cycle's event; saturates instead of wrapping.
    always_comb begin
        spike_inc = spike_cnt_q;
        if (spike_evt && (spike_cnt_q != CNT_MAX)) begin
            spike_inc = spike_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            win_cnt_q   <= '0;
            spike_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            win_cnt_q   <= win_cnt_d;
            spike_cnt_q <= spike_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        win_cnt_d   = win_cnt_q;
        spike_cnt_d = spike_cnt_q;
        win_end     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                win_cnt_d   = '0;
                spike_cnt_d = '0;
                if (enable_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable_i) begin
                    // Partial window is abandoned without a result.
                    state_d     = ST_IDLE;
                    win_cnt_d   = '0;
                    spike_cnt_d = '0;
                end else if (win_cnt_q == WIN_LAST) begin
                    // Next window starts immediately, no gap cycle.
                    win_end     = 1'b1;
                    win_cnt_d   = '0;
                    spike_cnt_d = '0;
                end else begin
                    win_cnt_d   = win_cnt_q + WIN_W'(1);
                    spike_cnt_d = spike_inc;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                win_cnt_d   = '0;
                spike_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        count_ext = 32'(spike_inc);
        if (count_ext < 32'(LOW_THR)) begin
            win_class = CLASS_LOW;
        end else if (count_ext > 32'(HIGH_THR)) begin
            win_class = CLASS_HIGH;
        end else begin
            win_class = CLASS_NORMAL;
        end
    end

    assign transfer    = result_valid_o & result_ready_i;
    // A finishing window may replace the held result only if that result is
    // absent or leaving on this same edge.
    assign load_result = win_end & (~result_valid_o | result_ready_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            result_valid_o <= 1'b0;
            spike_count_o  <= '0;
            class_o        <= CLASS_NORMAL;
            overrun_o      <= 1'b0;
        end else begin
            if (load_result) begin
                result_valid_o <= 1'b1;
                spike_count_o  <= spike_inc;
                class_o        <= win_class;
            end else if (transfer) begin
                result_valid_o <= 1'b0;
            end
            if (win_end && !load_result) begin
                overrun_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spike_window_classifier.sv
// ---------------------------------------------------------------------------
// Bench for spike_window_classifier. The main instance uses an 8-cycle
// window with a 4-bit counter and thresholds 2/4; a second instance with a
// 40-cycle window shows counter saturation. Expected results come from a
// window-level reference model that counts spike rises per window with plain
// integers and clamps only when the result is reported.
// ---------------------------------------------------------------------------
module tb_spike_window_classifier;

    localparam int W    = 8;
    localparam int W2   = 40;
    localparam int CW   = 4;
    localparam int LT   = 2;
    localparam int HT   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en, spk, rdy;
    logic          valid;
    logic [CW-1:0] count;
    logic [1:0]    cls;
    logic          ovr;

    logic          en2, spk2, rdy2;
    logic          valid2;
    logic [CW-1:0] count2;
    logic [1:0]    cls2;
    logic          ovr2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spike_window_classifier #(
        .WINDOW_CYCLES(W), .CNT_W(CW), .LOW_THR(LT), .HIGH_THR(HT)
    ) dut (
        .clk_i(clk), .rst_i(rst_n), .enable_i(en), .spike_i(spk),
        .result_ready_i(rdy), .result_valid_o(valid), .spike_count_o(count),
        .class_o(cls), .overrun_o(ovr)
    );

    spike_window_classifier #(
        .WINDOW_CYCLES(W2), .CNT_W(CW), .LOW_THR(LT), .HIGH_THR(HT)
    ) dut_sat (
        .clk_i(clk), .rst_i(rst_n), .enable_i(en2), .spike_i(spk2),
        .result_ready_i(rdy2), .result_valid_o(valid2), .spike_count_o(count2),
        .class_o(cls2), .overrun_o(ovr2)
    );

    // ---------------- reference model ----------------
    bit          m_run;
    int          m_pos;
    int          m_spikes;
    bit          m_prev;
    bit          m_valid;
    logic [CW-1:0] m_rcnt;
    logic [1:0]  m_rcls;
    bit          m_ovr;

    function automatic logic [1:0] ref_class(int c);
        if (c < LT) return 2'b01;
        if (c > HT) return 2'b10;
        return 2'b00;
    endfunction

    function automatic void model_reset();
        m_run = 0; m_pos = 0; m_spikes = 0; m_prev = 0;
        m_valid = 0; m_rcnt = '0; m_rcls = 2'b00; m_ovr = 0;
    endfunction

    function automatic void model_step();
        bit evt;
        bit xfer;
        bit loaded;
        int c;
        evt    = spk && !m_prev;
        xfer   = m_valid && rdy;
        loaded = 0;
        m_prev = spk;
        if (!m_run) begin
            if (en) begin
                m_run = 1; m_pos = 0; m_spikes = 0;
            end
        end else if (!en) begin
            m_run = 0; m_pos = 0; m_spikes = 0;
        end else begin
            if (evt) m_spikes++;
            if (m_pos == W - 1) begin
                c = (m_spikes > CMAX) ? CMAX : m_spikes;
                if (!m_valid || rdy) begin
                    m_valid = 1; m_rcnt = CW'(c); m_rcls = ref_class(c);
                    loaded = 1;
                end else begin
                    m_ovr = 1;
                end
                m_pos = 0; m_spikes = 0;
            end else begin
                m_pos++;
            end
        end
        if (!loaded && xfer) m_valid = 0;
    endfunction

    function automatic logic [7:0] model_vec();
        return {m_valid, m_rcnt, m_rcls, m_ovr};
    endfunction

    wire [7:0] dut_vec = {valid, count, cls, ovr};

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; en = 0; spk = 0; rdy = 0; en2 = 0; spk2 = 0; rdy2 = 0;
        model_reset();
        repeat (2) @(negedge clk);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", valid); end
        total++; if (count !== '0) begin bad++; $display("FAIL reset_count: got %0d expected 0", count); end
        total++; if (cls !== 2'b00) begin bad++; $display("FAIL reset_class: got %b expected 00", cls); end
        total++; if (ovr !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b expected 0", ovr); end
        total++; if (valid2 !== 1'b0) begin bad++; $display("FAIL reset_valid_sat: got %b expected 0", valid2); end
        rst_n = 1'b1;
    endtask

    task automatic test_normal();
        int vcount = 0;
        en = 1; rdy = 1; spk = 0;
        tick();
        for (int i = 0; i < W; i++) begin
            spk = (i == 1 || i == 3 || i == 5);
            tick();
            total++; if (dut_vec !== model_vec()) begin bad++; $display("FAIL normal_cyc%0d: got %b expected %b", i, dut_vec, model_vec()); end
            if (valid) vcount++;
        end
        total++;
        if (!(valid === 1'b1 && count === 4'd3 && cls === 2'b00)) begin
            bad++; $display("FAIL normal_result: got v=%b c=%0d cls=%b expected v=1 c=3 cls=00", valid, count, cls);
        end
        spk = 0;
        for (int i = 0; i < W - 1; i++) begin
            tick();
            if (valid) vcount++;
        end
        total++; if (vcount !== 1) begin bad++; $display("FAIL normal_pulse: got %0d valid cycles expected 1", vcount); end
        en = 0;
        tick();
    endtask

    task automatic test_level();
        en = 1; rdy = 1; spk = 0;
        tick();
        spk = 1;
        for (int i = 0; i < W; i++) begin
            tick();
            total++; if (dut_vec !== model_vec()) begin bad++; $display("FAIL level_cyc%0d: got %b expected %b", i, dut_vec, model_vec()); end
        end
        total++;
        if (!(valid === 1'b1 && count === 4'd1 && cls === 2'b01)) begin
            bad++; $display("FAIL level_result: got v=%b c=%0d cls=%b expected v=1 c=1 cls=01", valid, count, cls);
        end
        en = 0; spk = 0;
        tick();
    endtask

    task automatic test_saturation();
        en2 = 1; rdy2 = 1; spk2 = 0;
        tick();
        for (int i = 0; i < W2; i++) begin
            spk2 = (i % 2 == 0);
            tick();
        end
        total++;
        if (!(valid2 === 1'b1 && count2 === 4'd15 && cls2 === 2'b10)) begin
            bad++; $display("FAIL sat_result: got v=%b c=%0d cls=%b expected v=1 c=15 cls=10", valid2, count2, cls2);
        end
        spk2 = 0;
        tick();
        total++; if (valid2 !== 1'b0) begin bad++; $display("FAIL sat_release: got v=%b expected 0", valid2); end
        en2 = 0;
    endtask

    task automatic test_backpressure();
        en = 1; rdy = 0; spk = 0;
        tick();
        for (int i = 0; i < W; i++) begin
            spk = (i % 2 == 0);
            tick();
            total++; if (dut_vec !== model_vec()) begin bad++; $display("FAIL bp_w1_cyc%0d: got %b expected %b", i, dut_vec, model_vec()); end
        end
        total++;
        if (!(valid === 1'b1 && count === 4'd4 && cls === 2'b00 && ovr === 1'b0)) begin
            bad++; $display("FAIL bp_first: got v=%b c=%0d cls=%b ovr=%b expected 1 4 00 0", valid, count, cls, ovr);
        end
        for (int i = 0; i < W; i++) begin
            spk = (i == 3);
            tick();
            total++; if (dut_vec !== model_vec()) begin bad++; $display("FAIL bp_w2_cyc%0d: got %b expected %b", i, dut_vec, model_vec()); end
        end
        total++;
        if (!(valid === 1'b1 && count === 4'd4 && cls === 2'b00 && ovr === 1'b1)) begin
            bad++; $display("FAIL bp_held: got v=%b c=%0d cls=%b ovr=%b expected 1 4 00 1", valid, count, cls, ovr);
        end
        rdy = 1; spk = 0;
        tick();
        total++;
        if (!(valid === 1'b0 && ovr === 1'b1)) begin
            bad++; $display("FAIL bp_drain: got v=%b ovr=%b expected v=0 ovr=1", valid, ovr);
        end
        en = 0; rdy = 0;
        tick();
        rst_n = 1'b0;
        #1;
        model_reset();
        total++; if (ovr !== 1'b0) begin bad++; $display("FAIL bp_ovr_clear: got %b expected 0", ovr); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_simultaneous();
        en = 1; rdy = 0; spk = 0;
        tick();
        for (int i = 0; i < W; i++) begin
            spk = (i == 1 || i == 4);
            tick();
        end
        total++; if (dut_vec !== model_vec()) begin bad++; $display("FAIL simul_first: got %b expected %b", dut_vec, model_vec()); end
        for (int i = 0; i < W; i++) begin
            spk = (i == 2);
            rdy = (i == W - 1);
            tick();
            total++; if (dut_vec !== model_vec()) begin bad++; $display("FAIL simul_cyc%0d: got %b expected %b", i, dut_vec, model_vec()); end
        end
        total++;
        if (!(valid === 1'b1 && count === 4'd1 && cls === 2'b01 && ovr === 1'b0)) begin
            bad++; $display("FAIL simul_result: got v=%b c=%0d cls=%b ovr=%b expected 1 1 01 0", valid, count, cls, ovr);
        end
        rdy = 1; spk = 0;
        tick();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL simul_drain: got v=%b expected 0", valid); end
        en = 0;
        tick();
    endtask

    task automatic test_disable();
        int vcount = 0;
        en = 0; rdy = 1; spk = 0;
        repeat (2) tick();
        en = 1;
        tick();
        for (int i = 0; i < 4; i++) begin
            spk = (i == 0 || i == 2);
            tick();
            if (valid) vcount++;
        end
        en = 0; spk = 0;
        repeat (2) begin
            tick();
            if (valid) vcount++;
        end
        en = 1;
        tick();
        for (int i = 0; i < W; i++) begin
            spk = (i == 1 || i == 3 || i == 6);
            tick();
            total++; if (dut_vec !== model_vec()) begin bad++; $display("FAIL dis_cyc%0d: got %b expected %b", i, dut_vec, model_vec()); end
            if (i < W - 1 && valid) vcount++;
        end
        total++; if (vcount !== 0) begin bad++; $display("FAIL dis_partial: got %0d valid cycles expected 0", vcount); end
        total++;
        if (!(valid === 1'b1 && count === 4'd3 && cls === 2'b00)) begin
            bad++; $display("FAIL dis_result: got v=%b c=%0d cls=%b expected 1 3 00", valid, count, cls);
        end
        en = 0; spk = 0;
        tick();
    endtask

    task automatic test_async_reset();
        en = 1; rdy = 0; spk = 0;
        tick();
        for (int i = 0; i < W; i++) begin
            spk = (i == 0 || i == 2 || i == 4);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            spk = (i == 1);
            tick();
        end
        total++;
        if (!(valid === 1'b1 && count === 4'd3)) begin
            bad++; $display("FAIL arst_pre: got v=%b c=%0d expected v=1 c=3", valid, count);
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        total++;
        if ({valid, count, cls, ovr} !== 8'd0) begin
            bad++; $display("FAIL arst_outputs: got %b expected 00000000", {valid, count, cls, ovr});
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; rdy = 1; spk = 0;
        tick();
        for (int i = 0; i < W; i++) begin
            spk = (i == 1 || i == 5);
            tick();
            total++; if (dut_vec !== model_vec()) begin bad++; $display("FAIL arst_cyc%0d: got %b expected %b", i, dut_vec, model_vec()); end
        end
        total++;
        if (!(valid === 1'b1 && count === 4'd2 && cls === 2'b00)) begin
            bad++; $display("FAIL arst_restart: got v=%b c=%0d cls=%b expected 1 2 00", valid, count, cls);
        end
        en = 0; spk = 0;
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            en  = ($urandom_range(0, 15) != 0);
            spk = $urandom_range(0, 1);
            rdy = (n < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            tick();
            total++; if (dut_vec !== model_vec()) begin bad++; $display("FAIL random_%0d: got %b expected %b", n, dut_vec, model_vec()); end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_level();
        test_saturation();
        test_backpressure();
        test_simultaneous();
        test_disable();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
